// File: rtl/alu_drv_pkg.sv
// Shared definitions for the ALU stimulus driver: FSM states, ALU op codes
// and the bit layout of one operation slot inside a packet.
package alu_drv_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      GAP    = 2'd2,
      FINISH = 2'd3
   } drv_state_t;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_NOP  = 3'd0;
   localparam logic [OP_W-1:0] OP_ADD  = 3'd1;
   localparam logic [OP_W-1:0] OP_SUB  = 3'd2;
   localparam logic [OP_W-1:0] OP_MUL  = 3'd3;
   localparam logic [OP_W-1:0] OP_AND  = 3'd4;
   localparam logic [OP_W-1:0] OP_OR   = 3'd5;
   localparam logic [OP_W-1:0] OP_XOR  = 3'd6;
   localparam logic [OP_W-1:0] OP_PASS = 3'd7;

   // Slot layout: op in the low bits, then A, then B, each operand DATA_W wide.
   localparam int SLOT_OP_LSB = 0;

   function automatic int slot_a_lsb(input int data_w);
      return data_w;
   endfunction

   function automatic int slot_b_lsb(input int data_w);
      return 2 * data_w;
   endfunction

   function automatic int slot_width(input int data_w);
      return 3 * data_w;
   endfunction

endpackage

// File: rtl/alu_drv_timer.sv
// Per-operation watchdog: counts enabled cycles and flags the cycle in which
// the TIMEOUT_CYC-th enabled cycle is reached.
module alu_drv_timer #(
   parameter  int TIMEOUT_CYC = 64,
   localparam int TW          = $clog2(TIMEOUT_CYC + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   logic [TW-1:0] cnt;

   assign expire = enable && (cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (enable && !expire) begin
         cnt <= cnt + TW'(1);
      end
   end

endmodule

// File: rtl/alu_stim_driver.sv
// Packet-driven ALU stimulus driver: latches a packet of operations and
// issues them one at a time to an ALU, reporting each result or timeout.
module alu_stim_driver
   import alu_drv_pkg::*;
#(
   parameter  int DATA_W      = 8,
   parameter  int PKT_OPS     = 100,
   parameter  int TIMEOUT_CYC = 64,
   localparam int SLOT_W      = slot_width(DATA_W),
   localparam int CNT_W       = $clog2(PKT_OPS + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      pkt_valid,
   output logic                      pkt_ready,
   input  logic [PKT_OPS*SLOT_W-1:0] pkt_data,
   input  logic [CNT_W-1:0]          pkt_count,
   output logic [DATA_W-1:0]         alu_a,
   output logic [DATA_W-1:0]         alu_b,
   output logic [OP_W-1:0]           alu_op,
   output logic                      alu_start,
   input  logic                      alu_done,
   input  logic [2*DATA_W-1:0]       alu_result,
   output logic                      res_valid,
   output logic [2*DATA_W-1:0]       res_data,
   output logic [CNT_W-1:0]          res_index,
   output logic                      res_timeout,
   input  logic                      abort,
   output logic                      busy,
   output logic                      pkt_done,
   output logic                      pkt_aborted,
   output logic [15:0]               err_count
);

   localparam int               A_LSB   = slot_a_lsb(DATA_W);
   localparam int               B_LSB   = slot_b_lsb(DATA_W);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(PKT_OPS);

   drv_state_t                state;
   drv_state_t                state_next;
   logic [PKT_OPS*SLOT_W-1:0] pkt_reg;
   logic [CNT_W-1:0]          count;
   logic [CNT_W-1:0]          index;
   logic [CNT_W-1:0]          index_inc;
   logic [CNT_W-1:0]          count_clamped;
   logic [31:0]               slot_base;
   logic                      accept;
   logic                      take_done;
   logic                      take_expire;
   logic                      take_abort;
   logic                      timer_expire;

   assign count_clamped = (pkt_count > MAX_CNT) ? MAX_CNT : pkt_count;
   assign index_inc     = index + CNT_W'(1);
   assign slot_base     = 32'(index) * 32'(SLOT_W);

   alu_drv_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (state != RUN),
      .enable (state == RUN),
      .expire (timer_expire)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // abort outranks alu_done, which outranks the watchdog in the same cycle
   always_comb begin
      state_next  = state;
      accept      = 1'b0;
      take_done   = 1'b0;
      take_expire = 1'b0;
      take_abort  = 1'b0;
      case (state)
         IDLE: begin
            if (pkt_valid) begin
               accept     = 1'b1;
               state_next = (count_clamped == '0) ? FINISH : RUN;
            end
         end
         RUN: begin
            if (abort) begin
               take_abort = 1'b1;
               state_next = IDLE;
            end else if (alu_done) begin
               take_done  = 1'b1;
               state_next = GAP;
            end else if (timer_expire) begin
               take_expire = 1'b1;
               state_next  = GAP;
            end
         end
         GAP: begin
            if (abort) begin
               take_abort = 1'b1;
               state_next = IDLE;
            end else if (index_inc == count) begin
               state_next = FINISH;
            end else begin
               state_next = RUN;
            end
         end
         FINISH: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign pkt_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign alu_start = (state == RUN);

   // Operands come straight from the latched packet; index is frozen during RUN
   assign alu_a  = alu_start ? pkt_reg[slot_base + 32'(A_LSB) +: DATA_W] : '0;
   assign alu_b  = alu_start ? pkt_reg[slot_base + 32'(B_LSB) +: DATA_W] : '0;
   assign alu_op = alu_start ? pkt_reg[slot_base + 32'(SLOT_OP_LSB) +: OP_W] : '0;

   always_ff @(posedge clk) begin
      if (accept) begin
         pkt_reg <= pkt_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count       <= '0;
         index       <= '0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_index   <= '0;
         res_timeout <= 1'b0;
         pkt_done    <= 1'b0;
         pkt_aborted <= 1'b0;
         err_count   <= '0;
      end else begin
         res_valid   <= take_done || take_expire;
         pkt_done    <= (state_next == FINISH) || take_abort;
         pkt_aborted <= take_abort;
         if (accept) begin
            count <= count_clamped;
            index <= '0;
         end
         if (state == GAP) begin
            index <= index_inc;
         end
         if (take_done) begin
            res_data    <= alu_result;
            res_index   <= index;
            res_timeout <= 1'b0;
         end
         if (take_expire) begin
            res_data    <= '0;
            res_index   <= index;
            res_timeout <= 1'b1;
            if (err_count != 16'hFFFF) begin
               err_count <= err_count + 16'd1;
            end
         end
      end
   end

endmodule

// File: doc/alu_stim_driver.md
ALU_STIM_DRIVER -- requirements
Module: alu_stim_driver

Interface
REQ-001 SHALL have parameter DATA_W, default 8, ALU operand width (>=3).
REQ-002 SHALL have parameter PKT_OPS, default 100, max operations per packet.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 64, max cycles waiting for alu_done per operation.
REQ-004 SHALL derive SLOT_W = 3*DATA_W and CNT_W = clog2(PKT_OPS+1).
REQ-005 SHALL have port: clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports: pkt_valid in 1, pkt_ready out 1, packet load handshake.
REQ-008 SHALL have port: pkt_data  in  PKT_OPS*SLOT_W  slot k at [k*SLOT_W +: SLOT_W]; within slot, op [2:0], A [2*DATA_W-1:DATA_W], B [3*DATA_W-1:2*DATA_W].
REQ-009 SHALL have port: pkt_count  in  CNT_W  number of valid slots, counted from slot 0.
REQ-010 SHALL have ports: alu_a out DATA_W, alu_b out DATA_W, alu_op out 3, alu_start out 1.
REQ-011 SHALL have ports: alu_done in 1, alu_result in 2*DATA_W.
REQ-012 SHALL have ports: res_valid out 1, res_data out 2*DATA_W, res_index out CNT_W, res_timeout out 1.
REQ-013 SHALL have ports: abort in 1, busy out 1, pkt_done out 1 (pulse), pkt_aborted out 1, err_count out 16.

Function
REQ-014 SHALL use FSM states IDLE, RUN, GAP, FINISH.
REQ-015 IDLE: pkt_ready=1; on pkt_valid&pkt_ready, latch pkt_data and min(pkt_count,PKT_OPS), index=0, go RUN (or FINISH if count=0).
REQ-016 RUN: drive alu_a/alu_b/alu_op from slot[index], alu_start=1 held until alu_done or timeout.
REQ-017 On alu_done in RUN, next cycle: res_valid=1 one cycle, res_data=alu_result, res_index=index, res_timeout=0; go GAP.
REQ-018 If TIMEOUT_CYC cycles elapse in RUN without alu_done: res_valid=1, res_data=0, res_timeout=1, err_count+1 (saturating at 16'hFFFF), go GAP.
REQ-019 GAP: alu_start=0 for exactly one cycle; index+1; if index+1==count go FINISH, else RUN.
REQ-020 FINISH: pkt_done=1 for one cycle, pkt_aborted=0, return to IDLE.
REQ-021 Operand/op outputs SHALL be stable for the whole RUN interval of an operation.
REQ-022 abort in RUN/GAP: drop alu_start next cycle, no res_valid for the in-flight operation, pulse pkt_done with pkt_aborted=1, go IDLE; abort in IDLE ignored.
REQ-023 abort and alu_done in the same cycle: abort wins, result discarded.
REQ-024 alu_done outside RUN SHALL be ignored.
REQ-025 pkt_ready=0 and busy=1 in all states except IDLE; new packets never overwrite a running one.
REQ-026 pkt_count > PKT_OPS SHALL be clamped to PKT_OPS.
REQ-027 Throughput: per operation, RUN cycles + 1 GAP cycle; minimum 2 cycles per operation when alu_done returns in the first RUN cycle.

Reset
REQ-028 On reset: state IDLE, alu_start=0, alu_a=alu_b=0, alu_op=0, res_valid=0, res_data=0, res_index=0, res_timeout=0.
REQ-029 On reset: pkt_done=0, pkt_aborted=0, busy=0, err_count=0, pkt_ready=1 from the first cycle after reset deasserts.
REQ-030 Reset mid-packet SHALL discard the packet with no pkt_done pulse.

Structure
REQ-031 Shared package alu_drv_pkg SHALL hold the FSM state enum, ALU op encodings (3-bit), and slot field offset functions of DATA_W.
REQ-032 Timeout counting SHALL be a sub-module alu_drv_timer (clear, enable, expire at TIMEOUT_CYC).
REQ-033 Slot selection SHALL be an indexed part-select of the latched packet register; no shifting of the packet.

Verification
REQ-034 Single op A=8'h05, B=8'h03, op=add(1), ALU done after 1 cycle -> res_valid once, res_data=16'h0008, res_index=0, pkt_done one cycle later.
REQ-035 pkt_count=100, multiply ops A=k, B=2 -> 100 res_valid pulses, res_index 0..99 in order, res_data=2k, one GAP cycle between every alu_start pulse.
REQ-036 ALU never asserts done, TIMEOUT_CYC=64, count=2 -> two results with res_timeout=1, res_data=0, err_count=2, start high exactly 64 cycles each.
REQ-037 abort asserted in the same cycle as alu_done on op 3 of 10 -> no res_valid for op 3, pkt_done with pkt_aborted=1, pkt_ready=1 next cycle.
REQ-038 reset asserted during RUN of op 5 -> all outputs at reset values next cycle, no pkt_done; new packet with count=0 -> immediate pkt_done, no alu_start.
